// File: rtl/jp_pad_emu.sv
// Two-controller NES joypad emulator: 4021-style shift registers answering jp_latch/jp_clk.
// Optional turbo masking is built only when JOYPAD_TURBO_EN is defined.
module jp_pad_emu #(
    parameter int SYNC_STAGES = 2,
    parameter int TURBO_DIV   = 4
) (
    input  logic       clk_in,
    input  logic       nres_in,
    input  logic       jp_clk_in,
    input  logic       jp_latch_in,
    output logic       jp_data1_out,
    output logic       jp_data2_out,
    input  logic       btn_wr_in,
    input  logic [2:0] btn_sel_in,
    input  logic [7:0] btn_d_in
);

    if (SYNC_STAGES < 1 || SYNC_STAGES > 3) begin : g_bad_sync
        $error("jp_pad_emu: SYNC_STAGES must be 1..3");
    end
    if (TURBO_DIV < 1 || TURBO_DIV > 15) begin : g_bad_div
        $error("jp_pad_emu: TURBO_DIV must be 1..15");
    end

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] latch_sync;
    logic                   clk_d;
    logic                   latch_d;
    logic                   clk_s;
    logic                   latch_s;
    logic                   clk_rise;
    logic                   latch_fall;

    logic [7:0] btn [2];
    logic [1:0] conn;
    logic [7:0] eff [2];
    logic [7:0] sr  [2];
    logic [3:0] cnt [2];
    logic [1:0] data;

    assign clk_s      = clk_sync[SYNC_STAGES-1];
    assign latch_s    = latch_sync[SYNC_STAGES-1];
    assign clk_rise   = clk_s & ~clk_d;
    assign latch_fall = ~latch_s & latch_d;

    // NOTE: every sequential block uses non-blocking assignments so all flops
    // sample pre-edge values and the synchronizer chain shifts one stage per clock.
    always_ff @(posedge clk_in) begin
        if (!nres_in) begin
            clk_sync   <= '0;
            latch_sync <= '0;
            clk_d      <= 1'b0;
            latch_d    <= 1'b0;
        end else begin
            clk_sync[0]   <= jp_clk_in;
            latch_sync[0] <= jp_latch_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                clk_sync[i]   <= clk_sync[i-1];
                latch_sync[i] <= latch_sync[i-1];
            end
            clk_d   <= clk_s;
            latch_d <= latch_s;
        end
    end

`ifdef JOYPAD_TURBO_EN
    logic [7:0] turbo [2];
    logic [3:0] tcnt;
    logic       phase;

    // Phase flips every TURBO_DIV completed latch strobes.
    always_ff @(posedge clk_in) begin
        if (!nres_in) begin
            tcnt  <= '0;
            phase <= 1'b0;
        end else if (latch_fall) begin
            if (tcnt == 4'(TURBO_DIV - 1)) begin
                tcnt  <= '0;
                phase <= ~phase;
            end else begin
                tcnt <= tcnt + 4'd1;
            end
        end
    end
`endif

    always_ff @(posedge clk_in) begin
        if (!nres_in) begin
            btn[0] <= '0;
            btn[1] <= '0;
            conn   <= '0;
`ifdef JOYPAD_TURBO_EN
            turbo[0] <= '0;
            turbo[1] <= '0;
`endif
        end else if (btn_wr_in) begin
            case (btn_sel_in)
                3'd0: btn[0] <= btn_d_in;
                3'd1: btn[1] <= btn_d_in;
`ifdef JOYPAD_TURBO_EN
                3'd2: turbo[0] <= btn_d_in;
                3'd3: turbo[1] <= btn_d_in;
`endif
                3'd4: conn <= btn_d_in[1:0];
                default: ;
            endcase
        end
    end

    // NOTE: combinational outputs are fully assigned on every path, so no latch is inferred.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
`ifdef JOYPAD_TURBO_EN
            eff[p] = btn[p] & ~(turbo[p] & {8{~phase}});
`else
            eff[p] = btn[p];
`endif
        end
    end

    // NOTE: the shift registers are tiny, so they get a real reset; cnt=8 makes
    // a post-reset read look like an exhausted frame until the next latch.
    always_ff @(posedge clk_in) begin
        if (!nres_in) begin
            for (int p = 0; p < 2; p++) begin
                sr[p]  <= '0;
                cnt[p] <= 4'd8;
            end
            data <= 2'b11;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (latch_s) begin
                    sr[p]  <= eff[p];
                    cnt[p] <= '0;
                end else if (clk_rise && cnt[p] != 4'd8) begin
                    sr[p]  <= {1'b0, sr[p][7:1]};
                    cnt[p] <= cnt[p] + 4'd1;
                end

                // Serial data is active-low; an absent pad reads all ones.
                if (!conn[p]) begin
                    data[p] <= 1'b1;
                end else if (cnt[p] == 4'd8) begin
                    data[p] <= 1'b0;
                end else begin
                    data[p] <= ~sr[p][0];
                end
            end
        end
    end

    assign jp_data1_out = data[0];
    assign jp_data2_out = data[1];

endmodule

// File: doc/jp_pad_emu.md
# jp_pad_emu

Emulates the far end of the NES joypad serial interface: two standard controllers, each modelled as a 4021-style parallel-in/serial-out shift register. The block responds to the `jp_latch`/`jp_clk` strobes issued by the rp2a03 joypad unit and drives `jp_data1`/`jp_data2` back to it. Button state is written through a small host register port, fed by the hci block or a future USB/PS2 front end. It replaces the constant `1'b1` tie-offs on `NES_JOYPAD_DATA1`/`NES_JOYPAD_DATA2` in `nes_top`.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchronizer flops on `jp_clk_in`/`jp_latch_in`. Legal range 1–3.
- `TURBO_DIV`, 4: number of latch pulses per turbo phase toggle. Legal range 1–15. Used only with `JOYPAD_TURBO_EN`.

Ports:
- `clk_in` in 1: system clock (CLK_100MHZ).
- `nres_in` in 1: reset, synchronous, active-low.
- `jp_clk_in` in 1: shift clock from rp2a03 (`jp_clk`).
- `jp_latch_in` in 1: parallel-load strobe from rp2a03 (`jp_latch`).
- `jp_data1_out` out 1: pad 1 serial data, active-low (0 = pressed).
- `jp_data2_out` out 1: pad 2 serial data, active-low.
- `btn_wr_in` in 1: host write strobe, one cycle.
- `btn_sel_in` in 3: register select. 0 = pad1 buttons, 1 = pad2 buttons, 2 = pad1 turbo mask, 3 = pad2 turbo mask, 4 = connect bits [1:0]. Values 5–7 are ignored.
- `btn_d_in` in 8: write data. Buttons are active-high. Bit order is b0 A, b1 B, b2 Select, b3 Start, b4 Up, b5 Down, b6 Left, b7 Right.

## Operation
- Host registers: `btn1`, `btn2`, `turbo1`, `turbo2`, `conn[1:0]`. Each is written on `btn_wr_in`. All reset to 0.
- Synchronizers: `jp_clk_in` and `jp_latch_in` each pass through `SYNC_STAGES` flops.
  - One extra flop on the synchronized `jp_clk` supplies the rising-edge detect `clk_rise`.
  - The same structure on the synchronized latch supplies the falling-edge detect `latch_fall`.
- Per-pad state: 8-bit shift register `sr` and 4-bit counter `cnt`, which saturates at 8.
- Effective buttons: `eff = btn & ~(turbo & {8{~phase}})`. Without the turbo feature, `eff = btn`.
- Per pad, each clock, in priority order:
  1. Latch high (synchronized): `sr <= eff`, `cnt <= 0`, on every cycle. Host writes made while the latch is high are therefore visible. Any `clk_rise` in the same cycle is ignored.
  2. `clk_rise` with latch low and `cnt < 8`: `sr <= {1'b0, sr[7:1]}`, `cnt <= cnt + 1`.
  3. `clk_rise` with `cnt == 8`: no change.
- Host writes while the latch is low change only the host register. The in-flight `sr` is unaffected until the next latch.
- A host write and a latch in the same cycle: the load uses the old register value. The new value is loaded on the next latch-high cycle.
- Output register, per pad:
  - `data <= 1` if `conn` bit = 0 (disconnected; reads as "no pad").
  - Otherwise `data <= 0` if `cnt == 8`. This matches the official-pad behaviour where reads after the 8th return 1.
  - Otherwise `data <= ~sr[0]`.
- Reset: `sr` = 0, `cnt` = 8, `phase` = 0, `turbo` counter = 0. Both outputs = 1. Reset mid-frame aborts the read, and the next latch starts cleanly.

## Timing
- From a `jp_latch_in` rising edge, `jp_data*_out` reflects the A bit after `SYNC_STAGES`+2 clocks.
- From a `jp_clk_in` rising edge, the next bit appears after `SYNC_STAGES`+2 clocks.
- Outputs are registered with no combinational input-to-output path.
- Strobes shorter than `SYNC_STAGES`+1 clocks, high or low, are not guaranteed to be seen. The rp2a03 strobes are far longer.
- Any write to `conn` takes effect on the output 1 clock after the write.

## Configuration
- `JOYPAD_TURBO_EN` defined:
  - A 4-bit counter increments on each `latch_fall`.
  - On reaching `TURBO_DIV`-1 it clears and `phase` toggles.
  - Buttons set in `turbo*` are reported pressed only when `phase` = 1.
- `JOYPAD_TURBO_EN` undefined:
  - `turbo*` registers, the counter and `phase` are not built.
  - Writes to selects 2 and 3 are ignored.
  - `eff = btn`.

## Test plan
- Reset, then no writes, then latch + 8 clocks: both outputs stay 1 throughout.
- `conn` = 2'b01, `btn1` = 8'h09 (A+Start), then latch + 8 clocks: data1 sequence 0,1,1,0,1,1,1,1. A 9th and 10th clock read 0. data2 stays 1.
- `btn1` = 8'hFF written after the 3rd shift with `btn1` = 0: the remaining bits stay 1. The next latch + 8 clocks yields eight 0s.
- `jp_clk_in` pulse while latch high, `btn1` = 8'h02: no shift occurs. After latch falls the first bit = 1 (A) and the second = 0 (B).
- `nres_in` low for 1 clock after the 4th shift: the output returns to 1 on the next clock. A fresh latch restarts from the A bit.
- `JOYPAD_TURBO_EN`, `TURBO_DIV` = 2, `btn1` = `turbo1` = 8'h01: the A bit reads released, released, pressed, pressed over four successive latch frames.
